// File: rtl/motor_move_sequencer.sv
// Move sequencer: splits absolute-position moves into bounded, ramped step segments for the
// single-axis step generator and tracks live axis position from the generator's step pulses.
module motor_move_sequencer #(
    parameter int unsigned POS_W          = 19,
    parameter int unsigned SEG_MAX        = 2047,
    parameter logic [15:0] RAMP_START_DIV = 16'hFFFF,
    parameter logic [15:0] RAMP_DEC       = 16'd4096,
    parameter int unsigned ISSUE_TIMEOUT  = 1023
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [POS_W-1:0] cmd_target,
    input  logic [15:0]      cmd_divider,
    input  logic             abort,
    input  logic             pos_load,
    input  logic [POS_W-1:0] pos_load_value,
    output logic [10:0]      gen_steps_to_go,
    output logic             gen_dir_input,
    output logic [15:0]      gen_divider,
    input  logic             gen_active,
    input  logic             gen_step,
    input  logic             gen_dir,
    output logic [POS_W-1:0] cur_position,
    output logic             busy,
    output logic             done,
    output logic             timeout_err
);

    localparam int unsigned SEG_W   = 11;
    localparam int unsigned DIV_W   = 16;
    localparam int unsigned DELTA_W = POS_W + 1;
    localparam int unsigned WAIT_W  = $clog2(ISSUE_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_ISSUE = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [POS_W-1:0]   target_r, target_nxt;
    logic [DIV_W-1:0]   cruise_r, cruise_nxt;
    logic [DELTA_W-1:0] remaining, remaining_nxt;
    logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
    logic               abort_latched, abort_nxt;
    logic               step_q;
    logic [SEG_W-1:0]   steps_nxt;
    logic               dir_in_nxt;
    logic [DIV_W-1:0]   divider_nxt;
    logic [POS_W-1:0]   position_nxt;
    logic               done_nxt;
    logic               timeout_nxt;

    logic               accept;
    logic [DELTA_W-1:0] delta;
    logic [DELTA_W-1:0] delta_mag;
    logic               delta_zero;
    logic [DIV_W-1:0]   start_div;
    logic               issue_expired;
    logic               stop_after_seg;

    function automatic logic [SEG_W-1:0] seg_len(input logic [DELTA_W-1:0] rem);
        if (rem >= DELTA_W'(SEG_MAX)) return SEG_W'(SEG_MAX);
        return SEG_W'(rem);
    endfunction

    // Ramp step toward cruise: subtract saturates at zero, then floor at the cruise divider.
    function automatic logic [DIV_W-1:0] ramp_next(input logic [DIV_W-1:0] cur,
                                                  input logic [DIV_W-1:0] cruise);
        logic [DIV_W-1:0] dec;
        dec = (cur >= RAMP_DEC) ? (cur - RAMP_DEC) : '0;
        return (dec > cruise) ? dec : cruise;
    endfunction

    assign cmd_ready      = (state == S_IDLE) & ~pos_load;
    assign busy           = (state != S_IDLE);
    assign accept         = cmd_ready & cmd_valid;
    assign delta          = {target_r[POS_W-1], target_r} - {cur_position[POS_W-1], cur_position};
    assign delta_mag      = delta[DELTA_W-1] ? (~delta + DELTA_W'(1)) : delta;
    assign delta_zero     = (delta == '0);
    assign start_div      = (cruise_r > RAMP_START_DIV) ? cruise_r : RAMP_START_DIV;
    assign issue_expired  = (wait_cnt == WAIT_W'(ISSUE_TIMEOUT));
    assign stop_after_seg = (remaining == '0) | abort_latched | abort;

    // State register
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_CALC;
            S_CALC:  state_nxt = delta_zero ? S_IDLE : S_ISSUE;
            S_ISSUE: begin
                if (gen_active)         state_nxt = S_RUN;
                else if (issue_expired) state_nxt = S_IDLE;
            end
            S_RUN:   if (!gen_active) state_nxt = stop_after_seg ? S_IDLE : S_ISSUE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output and datapath next values; gen_divider doubles as the ramp state
    always_comb begin
        target_nxt    = target_r;
        cruise_nxt    = cruise_r;
        remaining_nxt = remaining;
        wait_nxt      = wait_cnt;
        abort_nxt     = abort_latched;
        steps_nxt     = gen_steps_to_go;
        dir_in_nxt    = gen_dir_input;
        divider_nxt   = gen_divider;
        done_nxt      = 1'b0;
        timeout_nxt   = timeout_err;
        position_nxt  = cur_position;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    target_nxt  = cmd_target;
                    cruise_nxt  = cmd_divider;
                    abort_nxt   = 1'b0;
                    timeout_nxt = 1'b0;
                end
            end
            S_CALC: begin
                if (delta_zero) begin
                    done_nxt = 1'b1;
                end else begin
                    remaining_nxt = delta_mag;
                    steps_nxt     = seg_len(delta_mag);
                    dir_in_nxt    = ~delta[DELTA_W-1];
                    divider_nxt   = start_div;
                    wait_nxt      = '0;
                end
            end
            S_ISSUE: begin
                if (gen_active) begin
                    steps_nxt     = '0;
                    remaining_nxt = remaining - DELTA_W'(gen_steps_to_go);
                end else if (issue_expired) begin
                    steps_nxt   = '0;
                    timeout_nxt = 1'b1;
                    done_nxt    = 1'b1;
                end else begin
                    wait_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            S_RUN: begin
                if (!gen_active) begin
                    if (stop_after_seg) begin
                        done_nxt = 1'b1;
                    end else begin
                        steps_nxt   = seg_len(remaining);
                        divider_nxt = ramp_next(gen_divider, cruise_r);
                        wait_nxt    = '0;
                    end
                end
            end
            default: ;
        endcase

        if ((state != S_IDLE) && abort) abort_nxt = 1'b1;

        // Position: a load in IDLE overrides any concurrent step edge
        if ((state == S_IDLE) && pos_load) begin
            position_nxt = pos_load_value;
        end else if (gen_step && !step_q) begin
            position_nxt = gen_dir ? (cur_position + POS_W'(1)) : (cur_position - POS_W'(1));
        end
    end

    // Datapath and output registers
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            target_r        <= '0;
            cruise_r        <= '0;
            remaining       <= '0;
            wait_cnt        <= '0;
            abort_latched   <= 1'b0;
            step_q          <= 1'b0;
            gen_steps_to_go <= '0;
            gen_dir_input   <= 1'b0;
            gen_divider     <= '0;
            cur_position    <= '0;
            done            <= 1'b0;
            timeout_err     <= 1'b0;
        end else begin
            target_r        <= target_nxt;
            cruise_r        <= cruise_nxt;
            remaining       <= remaining_nxt;
            wait_cnt        <= wait_nxt;
            abort_latched   <= abort_nxt;
            step_q          <= gen_step;
            gen_steps_to_go <= steps_nxt;
            gen_dir_input   <= dir_in_nxt;
            gen_divider     <= divider_nxt;
            cur_position    <= position_nxt;
            done            <= done_nxt;
            timeout_err     <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_motor_move_sequencer.sv
// Directed bench for motor_move_sequencer with a behavioural step-generator model
// (latch on idle, dwell on direction change, fixed step period).
module tb_motor_move_sequencer;

    localparam int STEP_PER = 4;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [18:0] cmd_target = '0;
    logic [15:0] cmd_divider = '0;
    logic        abort = 1'b0;
    logic        pos_load = 1'b0;
    logic [18:0] pos_load_value = '0;
    logic [10:0] gen_steps_to_go;
    logic        gen_dir_input;
    logic [15:0] gen_divider;
    logic        gen_active;
    logic        gen_step;
    logic        gen_dir;
    logic [18:0] cur_position;
    logic        busy;
    logic        done;
    logic        timeout_err;

    int          errors = 0;
    int          checks = 0;
    bit          gen_en = 1'b1;
    int          model_steps = 0;
    int          log_steps[$];
    logic [15:0] log_div[$];
    logic        log_dir[$];

    motor_move_sequencer dut (
        .CLK(CLK), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_target(cmd_target), .cmd_divider(cmd_divider),
        .abort(abort), .pos_load(pos_load), .pos_load_value(pos_load_value),
        .gen_steps_to_go(gen_steps_to_go), .gen_dir_input(gen_dir_input),
        .gen_divider(gen_divider), .gen_active(gen_active),
        .gen_step(gen_step), .gen_dir(gen_dir),
        .cur_position(cur_position), .busy(busy), .done(done),
        .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    // Step generator model; it is not reset by the sequencer's reset
    initial begin : gen_model
        int   n;
        int   dwell;
        logic d;
        gen_active = 1'b0;
        gen_step   = 1'b0;
        gen_dir    = 1'b1;
        forever begin
            @(posedge CLK); #1;
            if (gen_en && !gen_active && gen_steps_to_go != 11'd0) begin
                n = int'(gen_steps_to_go);
                d = gen_dir_input;
                log_steps.push_back(n);
                log_div.push_back(gen_divider);
                log_dir.push_back(d);
                dwell = (d != gen_dir) ? 257 : 2;
                repeat (dwell) @(posedge CLK);
                #1;
                gen_dir    = d;
                gen_active = 1'b1;
                for (int i = 0; i < n; i++) begin
                    repeat (STEP_PER - 1) @(posedge CLK);
                    #1;
                    gen_step = 1'b1;
                    model_steps++;
                    @(posedge CLK); #1;
                    gen_step = 1'b0;
                end
                gen_active = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge CLK); #2;
    endtask

    task automatic clear_log();
        log_steps.delete();
        log_div.delete();
        log_dir.delete();
    endtask

    task automatic do_load(input logic [18:0] v);
        pos_load = 1'b1;
        pos_load_value = v;
        tick();
        pos_load = 1'b0;
    endtask

    task automatic send_cmd(input logic [18:0] t, input logic [15:0] div);
        cmd_target  = t;
        cmd_divider = div;
        cmd_valid   = 1'b1;
        tick();
        cmd_valid   = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit seen, output int cycles);
        seen = 1'b0;
        cycles = 0;
        while (!seen && cycles < bound) begin
            tick();
            cycles++;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic wait_active(input int bound, output bit seen);
        int n = 0;
        seen = 1'b0;
        while (!seen && n < bound) begin
            tick();
            n++;
            if (gen_active) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++; if (gen_steps_to_go !== 11'd0) begin errors++; $display("FAIL reset_steps: got %0d expected 0", gen_steps_to_go); end
        checks++; if (cur_position !== 19'd0) begin errors++; $display("FAIL reset_pos: got %0d expected 0", cur_position); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL reset_flags: busy=%0b done=%0b timeout=%0b expected 0", busy, done, timeout_err); end
        checks++; if (gen_divider !== 16'd0 || gen_dir_input !== 1'b0) begin errors++; $display("FAIL reset_gen: div=%h dir=%0b expected 0", gen_divider, gen_dir_input); end
        @(negedge CLK);
        reset = 1'b0;
        tick();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %0b expected 1", cmd_ready); end
    endtask

    task automatic test_short_move();
        bit seen; int cyc;
        clear_log();
        send_cmd(19'd5, 16'd100);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL short_busy: got %0b expected 1", busy); end
        wait_done(2000, seen, cyc);
        checks++; if (!seen) begin errors++; $display("FAIL short_done: no done within %0d cycles", cyc); end
        checks++; if (cur_position !== 19'd5) begin errors++; $display("FAIL short_pos: got %0d expected 5", cur_position); end
        checks++; if (log_steps.size() != 1) begin errors++; $display("FAIL short_segs: got %0d segments expected 1", log_steps.size()); end
        if (log_steps.size() == 1) begin
            checks++; if (log_steps[0] != 5 || log_div[0] !== 16'hFFFF || log_dir[0] !== 1'b1) begin errors++; $display("FAIL short_seg0: got steps=%0d div=%h dir=%0b expected 5 FFFF 1", log_steps[0], log_div[0], log_dir[0]); end
        end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL short_end: done=%0b busy=%0b expected 0 0", done, busy); end
        checks++; if (gen_divider !== 16'hFFFF || gen_dir_input !== 1'b1) begin errors++; $display("FAIL short_hold: div=%h dir=%0b expected FFFF 1", gen_divider, gen_dir_input); end
    endtask

    task automatic test_multi_segment();
        bit seen; int cyc;
        int          exp_steps[3] = '{2047, 2047, 906};
        logic [15:0] exp_div[3]   = '{16'hFFFF, 16'hEFFF, 16'hDFFF};
        do_load(19'd0);
        clear_log();
        send_cmd(19'd5000, 16'd1000);
        wait_done(30000, seen, cyc);
        checks++; if (!seen) begin errors++; $display("FAIL multi_done: no done within %0d cycles", cyc); end
        checks++; if (cur_position !== 19'd5000) begin errors++; $display("FAIL multi_pos: got %0d expected 5000", cur_position); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL multi_timeout: got %0b expected 0", timeout_err); end
        checks++; if (log_steps.size() != 3) begin errors++; $display("FAIL multi_segs: got %0d segments expected 3", log_steps.size()); end
        for (int i = 0; i < 3 && i < log_steps.size(); i++) begin
            checks++; if (log_steps[i] != exp_steps[i] || log_div[i] !== exp_div[i]) begin errors++; $display("FAIL multi_seg%0d: got steps=%0d div=%h expected %0d %h", i, log_steps[i], log_div[i], exp_steps[i], exp_div[i]); end
        end
    endtask

    task automatic test_negative();
        bit seen; int cyc;
        do_load(19'd100);
        clear_log();
        send_cmd(19'(-50), 16'd100);
        wait_done(3000, seen, cyc);
        checks++; if (!seen) begin errors++; $display("FAIL neg_done: no done within %0d cycles", cyc); end
        checks++; if (cur_position !== 19'(-50)) begin errors++; $display("FAIL neg_pos: got %0d expected -50", $signed(cur_position)); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL neg_timeout: got %0b expected 0", timeout_err); end
        checks++; if (log_steps.size() != 1) begin errors++; $display("FAIL neg_segs: got %0d segments expected 1", log_steps.size()); end
        if (log_steps.size() == 1) begin
            checks++; if (log_steps[0] != 150 || log_dir[0] !== 1'b0) begin errors++; $display("FAIL neg_seg0: got steps=%0d dir=%0b expected 150 0", log_steps[0], log_dir[0]); end
        end
    endtask

    task automatic test_zero_length();
        clear_log();
        send_cmd(19'(-50), 16'd100);
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL zero_calc: done=%0b busy=%0b expected 0 1", done, busy); end
        tick();
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zero_done: done=%0b busy=%0b expected 1 0", done, busy); end
        checks++; if (gen_steps_to_go !== 11'd0) begin errors++; $display("FAIL zero_steps: got %0d expected 0", gen_steps_to_go); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_pulse: got %0b expected 0", done); end
        checks++; if (log_steps.size() != 0) begin errors++; $display("FAIL zero_segs: got %0d segments expected 0", log_steps.size()); end
    endtask

    task automatic test_abort();
        bit seen; int cyc;
        do_load(19'd0);
        clear_log();
        send_cmd(19'd5000, 16'd1000);
        wait_active(2000, seen);
        checks++; if (!seen) begin errors++; $display("FAIL abort_active: generator never went active"); end
        repeat (100) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done(15000, seen, cyc);
        checks++; if (!seen) begin errors++; $display("FAIL abort_done: no done within %0d cycles", cyc); end
        checks++; if (cur_position !== 19'd2047) begin errors++; $display("FAIL abort_pos: got %0d expected 2047", cur_position); end
        checks++; if (log_steps.size() != 1 || busy !== 1'b0) begin errors++; $display("FAIL abort_segs: got %0d segments busy=%0b expected 1 0", log_steps.size(), busy); end
    endtask

    task automatic test_timeout();
        bit seen; int cyc;
        gen_en = 1'b0;
        clear_log();
        send_cmd(19'd2100, 16'd100);
        wait_done(1200, seen, cyc);
        checks++; if (!seen) begin errors++; $display("FAIL to_done: no done within %0d cycles", cyc); end
        checks++; if (cyc < 1000 || cyc > 1100) begin errors++; $display("FAIL to_latency: got %0d cycles expected 1000..1100", cyc); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_flag: got %0b expected 1", timeout_err); end
        checks++; if (gen_steps_to_go !== 11'd0 || busy !== 1'b0) begin errors++; $display("FAIL to_idle: steps=%0d busy=%0b expected 0 0", gen_steps_to_go, busy); end
        checks++; if (cur_position !== 19'd2047) begin errors++; $display("FAIL to_pos: got %0d expected 2047", cur_position); end
        gen_en = 1'b1;
        tick();
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %0b expected 1", timeout_err); end
        send_cmd(19'd2047, 16'd100);
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear: got %0b expected 0", timeout_err); end
        wait_done(10, seen, cyc);
    endtask

    task automatic test_pos_load();
        pos_load = 1'b1;
        pos_load_value = 19'd1234;
        cmd_valid = 1'b1;
        cmd_target = 19'd0;
        #1;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL load_ready: got %0b expected 0", cmd_ready); end
        tick();
        pos_load = 1'b0;
        cmd_valid = 1'b0;
        checks++; if (cur_position !== 19'd1234) begin errors++; $display("FAIL load_pos: got %0d expected 1234", cur_position); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL load_accept: busy=%0b expected 0", busy); end
        tick();
        checks++; if (busy !== 1'b0 || cur_position !== 19'd1234) begin errors++; $display("FAIL load_hold: busy=%0b pos=%0d expected 0 1234", busy, cur_position); end
    endtask

    task automatic test_reset_mid_run();
        bit seen; int snap; int n;
        do_load(19'd0);
        clear_log();
        send_cmd(19'd3000, 16'd1000);
        wait_active(2000, seen);
        checks++; if (!seen) begin errors++; $display("FAIL rst_active: generator never went active"); end
        repeat (40) tick();
        checks++; if (gen_divider !== 16'hFFFF || busy !== 1'b1) begin errors++; $display("FAIL rst_pre: div=%h busy=%0b expected FFFF 1", gen_divider, busy); end
        reset = 1'b1;
        #1;
        checks++; if (gen_steps_to_go !== 11'd0 || gen_divider !== 16'd0 || gen_dir_input !== 1'b0) begin errors++; $display("FAIL rst_gen: steps=%0d div=%h dir=%0b expected 0 0 0", gen_steps_to_go, gen_divider, gen_dir_input); end
        checks++; if (cur_position !== 19'd0 || busy !== 1'b0) begin errors++; $display("FAIL rst_state: pos=%0d busy=%0b expected 0 0", cur_position, busy); end
        n = 0;
        do begin @(negedge CLK); n++; end while (gen_step && n < 10);
        snap = model_steps;
        reset = 1'b0;
        n = 0;
        while (gen_active && n < 12000) begin tick(); n++; end
        checks++; if (gen_active) begin errors++; $display("FAIL rst_drain: generator still active after %0d cycles", n); end
        repeat (3) tick();
        checks++; if (cur_position !== 19'(model_steps - snap)) begin errors++; $display("FAIL rst_count: got %0d expected %0d", cur_position, model_steps - snap); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle: busy=%0b expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_short_move();
        test_multi_segment();
        test_negative();
        test_zero_length();
        test_abort();
        test_timeout();
        test_pos_load();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/motor_move_sequencer.md
Name: motor_move_sequencer

Overview:
- Converts absolute-position move commands into a sequence of bounded step segments for the single-axis step generator, whose step-count input is 11 bits wide.
- Tracks live signed axis position by counting generated step pulses.
- Applies a per-segment divider ramp from a slow start rate to the commanded rate.
- Sits between the host command/register layer and the step generator.

Parameters:
POS_W, 19, width of signed position and command target
SEG_MAX, 2047, maximum steps per issued segment (1..2047)
RAMP_START_DIV, 16'hFFFF, divider used for the first segment of every move
RAMP_DEC, 16'd4096, divider decrement applied between successive segments
ISSUE_TIMEOUT, 1023, cycles to wait for generator activeMode after issuing a segment (must be >= 300)

Ports:
CLK  in  1  system clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  move command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_target  in  POS_W  signed absolute target position
cmd_divider  in  16  cruise divider, clocks per step
abort  in  1  stop after the current segment
pos_load  in  1  overwrite position counter; honoured only in IDLE
pos_load_value  in  POS_W  value loaded by pos_load
gen_steps_to_go  out  11  to generator stepsToGo
gen_dir_input  out  1  to generator dirInput; 1 = positive
gen_divider  out  16  to generator divider
gen_active  in  1  generator activeMode
gen_step  in  1  generator step output
gen_dir  in  1  generator registered dir
cur_position  out  POS_W  signed live position
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at move end (normal, abort or zero-length)
timeout_err  out  1  sticky; set on issue timeout, cleared by next accepted command

Behaviour:
Reset values:
- All outputs and registers 0; state IDLE.
- Reset mid-move drops gen_steps_to_go to 0 immediately. The generator finishes its latched segment on its own; pulses it produces after reset release are still counted.

Position counter:
- Register gen_step; on each rising edge, cur_position += 1 if gen_dir = 1, else -= 1.
- Active in every state. Wraps modulo 2^POS_W.

Command handshake:
- cmd_ready = (state == IDLE) & ~pos_load.
- pos_load in IDLE loads cur_position = pos_load_value; it wins over cmd_valid in the same cycle.
- pos_load outside IDLE is ignored.

FSM:
- IDLE: on accept, latch target and cruise divider, clear abort_latched and timeout_err -> CALC.
- CALC (1 cycle):
  - delta = target - cur_position, POS_W+1-bit signed.
  - delta == 0: pulse done -> IDLE.
  - Otherwise: dir_r = ~delta[MSB]; remaining = |delta|; seg_div = max(RAMP_START_DIV, cruise) -> ISSUE.
- ISSUE:
  - Drive gen_steps_to_go = min(remaining, SEG_MAX), gen_dir_input = dir_r, gen_divider = seg_div.
  - On gen_active = 1: gen_steps_to_go <= 0, remaining -= segment -> RUN.
  - If the wait counter reaches ISSUE_TIMEOUT: set timeout_err, gen_steps_to_go <= 0, pulse done -> IDLE.
- RUN:
  - Hold gen_steps_to_go = 0 so the generator does not re-arm.
  - On gen_active = 0:
    - remaining == 0 or abort_latched: pulse done -> IDLE.
    - Otherwise: seg_div = max(seg_div - RAMP_DEC, cruise), saturating with no underflow -> ISSUE.
- abort: sampled in any non-IDLE state and latched. The current segment always completes; no further segment is issued. abort in IDLE is ignored.

Rules:
- gen_dir_input and gen_divider hold their last values outside ISSUE.
- Direction-change dwell inside the generator (~257 cycles) is absorbed by the ISSUE wait.
- done and cmd_ready never assert in the same cycle as a state exit from IDLE.

Test Plan:
- Reset, pos 0, cmd target=+5, divider=100 -> one segment: gen_steps_to_go=5, gen_dir_input=1, gen_divider=16'hFFFF; 5 step edges; cur_position=5; one done pulse.
- Pos 0, target=+5000, divider=1000 -> segments 2047/2047/906 with dividers FFFF/EFFF/DFFF; final cur_position=5000; no timeout_err.
- Pos 100, target=-50 -> gen_dir_input=0, 150 steps, cur_position=-50. A direction-change dwell precedes gen_active with no timeout.
- Target equals current position -> done pulse two cycles after accept; gen_steps_to_go never nonzero.
- Abort asserted during segment 1 of the +5000 move -> segment completes; cur_position=2047; done pulse; IDLE.
- gen_active tied 0 -> timeout_err set after ISSUE_TIMEOUT cycles, done pulses, IDLE.
- pos_load=1 with cmd_valid=1 in IDLE -> position loaded, command not accepted.
- reset asserted mid-RUN -> outputs 0 immediately.
